// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//   Bundles the ALU/LSU result handshakes and the registered write port of
//   writeback_arbiter.
//   master : execution-unit / register-file side (drives results, sees wb_*)
//   slave  : the arbiter itself
//   Signals
//     alu_valid/ready/rd/tag/data  ALU result handshake and payload
//     lsu_valid/ready/rd/tag/data  LSU result handshake and payload
//     wb_en/rd/tag/data/src        one-cycle write strobe and payload
interface writeback_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
);
   logic              alu_valid;
   logic              alu_ready;
   logic [4:0]        alu_rd;
   logic [TAG_W-1:0]  alu_tag;
   logic [DATA_W-1:0] alu_data;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [4:0]        lsu_rd;
   logic [TAG_W-1:0]  lsu_tag;
   logic [DATA_W-1:0] lsu_data;
   logic              wb_en;
   logic [4:0]        wb_rd;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_data;
   logic              wb_src;

   modport master (
      output alu_valid, alu_rd, alu_tag, alu_data,
      output lsu_valid, lsu_rd, lsu_tag, lsu_data,
      input  alu_ready, lsu_ready,
      input  wb_en, wb_rd, wb_tag, wb_data, wb_src
   );

   modport slave (
      input  alu_valid, alu_rd, alu_tag, alu_data,
      input  lsu_valid, lsu_rd, lsu_tag, lsu_data,
      output alu_ready, lsu_ready,
      output wb_en, wb_rd, wb_tag, wb_data, wb_src
   );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Collects ALU and LSU results into one FIFO per source and retires one
//   result per cycle, round-robin between sources, on a registered write
//   port (register file write + register-status busy clear by tag).
//   Ports
//     clk  : clock, all state on the rising edge
//     rst  : synchronous reset, active-high
//     bus  : writeback_arbiter_if.slave (ALU/LSU handshakes, wb_* outputs)
//   Source index 0 = ALU, 1 = LSU (also the encoding of wb_src).
//   Optional feature: define WB_BYPASS_EN to let a handshaked entry skip an
//   empty FIFO and be arbitrated in the same cycle (latency N+1 instead of N+2).
module writeback_arbiter #(
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   writeback_arbiter_if.slave bus
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int NSRC = 2;

   typedef struct packed {
      logic [4:0]        rd;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t [NSRC-1:0] in_ent;
   entry_t [NSRC-1:0] head;
   logic   [NSRC-1:0] in_valid, in_ready, hs, empty, full, req, push, pop, grant;

   assign in_valid  = {bus.lsu_valid, bus.alu_valid};
   assign in_ent[0] = {bus.alu_rd, bus.alu_tag, bus.alu_data};
   assign in_ent[1] = {bus.lsu_rd, bus.lsu_tag, bus.lsu_data};
   assign bus.alu_ready = in_ready[0];
   assign bus.lsu_ready = in_ready[1];

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      entry_t    mem [FIFO_DEPTH];
      logic [AW:0] wptr, rptr;

      // Extra pointer MSB separates full (MSBs differ) from empty (equal).
      assign empty[s]    = (wptr == rptr);
      assign full[s]     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      // Ready looks only at full, so a same-cycle pop never frees a slot early.
      assign in_ready[s] = ~full[s];
      assign hs[s]       = in_valid[s] & in_ready[s];
      assign pop[s]      = grant[s] & ~empty[s];
`ifdef WB_BYPASS_EN
      // An empty FIFO offers the incoming entry as its head; if that entry
      // wins the grant it goes straight to the write port and is not stored.
      assign req[s]  = ~empty[s] | hs[s];
      assign head[s] = empty[s] ? in_ent[s] : mem[rptr[AW-1:0]];
      assign push[s] = hs[s] & ~(grant[s] & empty[s]);
`else
      assign req[s]  = ~empty[s];
      assign head[s] = mem[rptr[AW-1:0]];
      assign push[s] = hs[s];
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push[s]) wptr <= wptr + 1'b1;
            if (pop[s])  rptr <= rptr + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push[s]) mem[wptr[AW-1:0]] <= in_ent[s];
      end
   end

   // Round-robin: on contention grant the source that did not win last.
   logic rr_last;
   logic any_req;
   logic gsel;

   always_comb begin
      any_req = |req;
      gsel    = (req[0] & req[1]) ? ~rr_last : req[1];
      grant   = '0;
      if (any_req) grant[gsel] = 1'b1;
   end

   logic              wb_en;
   logic [4:0]        wb_rd;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_data;
   logic              wb_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en   <= 1'b0;
         wb_rd   <= '0;
         wb_tag  <= '0;
         wb_data <= '0;
         wb_src  <= 1'b0;
         rr_last <= 1'b1;
      end else begin
         wb_en <= 1'b0;
         if (any_req) begin
            // An rd==0 entry still consumes its round-robin turn, but x0 is
            // never written and the port keeps its previous payload.
            rr_last <= gsel;
            if (head[gsel].rd != 5'd0) begin
               wb_en   <= 1'b1;
               wb_rd   <= head[gsel].rd;
               wb_tag  <= head[gsel].tag;
               wb_data <= head[gsel].data;
               wb_src  <= gsel;
            end
         end
      end
   end

   assign bus.wb_en   = wb_en;
   assign bus.wb_rd   = wb_rd;
   assign bus.wb_tag  = wb_tag;
   assign bus.wb_data = wb_data;
   assign bus.wb_src  = wb_src;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed bench for writeback_arbiter (FIFO_DEPTH=4). A cycle table covers
//   contention, alternation and backpressure; short hand-written sequences
//   cover single-result latency, back-to-back same rd, rd==0 round-robin,
//   an LSU-only burst and reset in the middle of traffic.
module tb_writeback_arbiter;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;
`ifdef WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [4:0]        rd;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } item_t;

   typedef struct {
      logic  av;
      item_t a;
      logic  lv;
      item_t b;
      logic  ar;
      logic  lr;
      logic  en;
      item_t w;
      logic  src;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   writeback_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   writeback_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic item_t mk_item(input int rd, input int tag, input logic [31:0] data);
      item_t it;
      it.rd   = 5'(rd);
      it.tag  = 4'(tag);
      it.data = data;
      return it;
   endfunction

   function automatic item_t ai(input int k);
      return mk_item(k + 1, k, 32'hA000_0000 + 32'(k));
   endfunction

   function automatic item_t bi(input int k);
      return mk_item(k + 16, k + 8, 32'hB000_0000 + 32'(k));
   endfunction

   function automatic vec_t mk(input logic av, input item_t a, input logic lv, input item_t b,
                               input logic ar, input logic lr, input logic en, input item_t w,
                               input logic src);
      vec_t v;
      v.av = av; v.a = a; v.lv = lv; v.b = b;
      v.ar = ar; v.lr = lr; v.en = en; v.w = w; v.src = src;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_wb(input string nm, input logic en, input item_t w, input logic src);
      chk({nm, ".wb_en"}, 64'(bus.wb_en), 64'(en));
      if (en) begin
         chk({nm, ".wb_rd"},   64'(bus.wb_rd),   64'(w.rd));
         chk({nm, ".wb_tag"},  64'(bus.wb_tag),  64'(w.tag));
         chk({nm, ".wb_data"}, 64'(bus.wb_data), 64'(w.data));
         chk({nm, ".wb_src"},  64'(bus.wb_src),  64'(src));
      end
   endtask

   task automatic drive(input logic av, input item_t a, input logic lv, input item_t b);
      bus.alu_valid = av;
      bus.alu_rd    = a.rd;
      bus.alu_tag   = a.tag;
      bus.alu_data  = a.data;
      bus.lsu_valid = lv;
      bus.lsu_rd    = b.rd;
      bus.lsu_tag   = b.tag;
      bus.lsu_data  = b.data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t  tbl[$];
      item_t no;
      item_t x;
      item_t y;
      no = '0;
      drive(1'b0, no, 1'b0, no);

      // Both sources saturated from empty: strict 0,1,0,1 alternation, the
      // LSU FIFO fills first, then the ALU FIFO, then the pipe drains.
      tbl.push_back(mk(1, ai(0), 1, bi(0), 1, 1, 0, no,    0));
      tbl.push_back(mk(1, ai(1), 1, bi(1), 1, 1, 0, no,    0));
      tbl.push_back(mk(1, ai(2), 1, bi(2), 1, 1, 1, ai(0), 0));
      tbl.push_back(mk(1, ai(3), 1, bi(3), 1, 1, 1, bi(0), 1));
      tbl.push_back(mk(1, ai(4), 1, bi(4), 1, 1, 1, ai(1), 0));
      tbl.push_back(mk(1, ai(5), 1, bi(5), 1, 1, 1, bi(1), 1));
      tbl.push_back(mk(1, ai(6), 1, bi(6), 1, 0, 1, ai(2), 0));
      tbl.push_back(mk(1, ai(7), 1, bi(6), 0, 1, 1, bi(2), 1));
      tbl.push_back(mk(0, no,    0, no,    1, 0, 1, ai(3), 0));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, bi(3), 1));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, ai(4), 0));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, bi(4), 1));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, ai(5), 0));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, bi(5), 1));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, ai(6), 0));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 1, bi(6), 1));
      tbl.push_back(mk(0, no,    0, no,    1, 1, 0, no,    0));

      // Power-on reset
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset.wb_en",     64'(bus.wb_en),     64'd0);
      chk("reset.wb_rd",     64'(bus.wb_rd),     64'd0);
      chk("reset.wb_tag",    64'(bus.wb_tag),    64'd0);
      chk("reset.wb_data",   64'(bus.wb_data),   64'd0);
      chk("reset.wb_src",    64'(bus.wb_src),    64'd0);
      chk("reset.alu_ready", 64'(bus.alu_ready), 64'd1);
      chk("reset.lsu_ready", 64'(bus.lsu_ready), 64'd1);

`ifndef WB_BYPASS_EN
      foreach (tbl[i]) begin
         drive(tbl[i].av, tbl[i].a, tbl[i].lv, tbl[i].b);
         #1;
         chk($sformatf("tbl%0d.alu_ready", i), 64'(bus.alu_ready), 64'(tbl[i].ar));
         chk($sformatf("tbl%0d.lsu_ready", i), 64'(bus.lsu_ready), 64'(tbl[i].lr));
         chk_wb($sformatf("tbl%0d", i), tbl[i].en, tbl[i].w, tbl[i].src);
         tick();
      end
`endif
      drive(1'b0, no, 1'b0, no);
      repeat (3) tick();

      // Single ALU result: wb_en exactly LAT cycles after the handshake.
      x = mk_item(5, 3, 32'hDEAD_BEEF);
      for (int k = 0; k < 4; k++) begin
         drive(k == 0, x, 1'b0, no);
         #1;
         chk_wb($sformatf("single.c%0d", k), k == LAT, x, 1'b0);
         tick();
      end

      // Same rd from ALU then LSU: both written, in grant order, own tags.
      x = mk_item(7, 1, 32'h1);
      y = mk_item(7, 2, 32'h2);
      for (int k = 0; k < LAT + 3; k++) begin
         drive(k == 0, x, k == 1, y);
         #1;
         if (k == LAT)          chk_wb($sformatf("samerd.c%0d", k), 1'b1, x, 1'b0);
         else if (k == LAT + 1) chk_wb($sformatf("samerd.c%0d", k), 1'b1, y, 1'b1);
         else                   chk_wb($sformatf("samerd.c%0d", k), 1'b0, no, 1'b0);
         tick();
      end
      drive(1'b0, no, 1'b0, no);
      repeat (2) tick();

      // rd==0 from ALU is dropped but counts as an ALU grant, so the LSU wins
      // the following contention even though the LSU won the last real one.
      for (int k = 0; k < LAT + 4; k++) begin
         x = (k == 0) ? mk_item(0, 5, 32'h1234) : mk_item(9, 6, 32'hAAAA);
         y = mk_item(10, 7, 32'hBBBB);
         drive(k <= 1, x, k == 1, y);
         #1;
         if (k == LAT + 1)      chk_wb($sformatf("rd0.c%0d", k), 1'b1, y, 1'b1);
         else if (k == LAT + 2) chk_wb($sformatf("rd0.c%0d", k), 1'b1, mk_item(9, 6, 32'hAAAA), 1'b0);
         else                   chk_wb($sformatf("rd0.c%0d", k), 1'b0, no, 1'b0);
         tick();
      end
      drive(1'b0, no, 1'b0, no);
      repeat (2) tick();

      // LSU-only burst of 6: never backpressured, all written in push order.
      for (int k = 0; k < 6 + LAT + 1; k++) begin
         drive(1'b0, no, k < 6, mk_item(k + 1, k, 32'hC000_0000 + 32'(k)));
         #1;
         chk($sformatf("burst.c%0d.lsu_ready", k), 64'(bus.lsu_ready), 64'd1);
         if (k >= LAT && k - LAT < 6)
            chk_wb($sformatf("burst.c%0d", k), 1'b1,
                   mk_item(k - LAT + 1, k - LAT, 32'hC000_0000 + 32'(k - LAT)), 1'b1);
         else
            chk_wb($sformatf("burst.c%0d", k), 1'b0, no, 1'b0);
         tick();
      end

      // Reset with both FIFOs holding entries: everything buffered is lost.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ai(k), 1'b1, bi(k));
         tick();
      end
      drive(1'b0, no, 1'b0, no);
      rst = 1'b1;
      tick();
      chk("midrst.during.wb_en", 64'(bus.wb_en), 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      #1;
      chk("midrst.alu_ready", 64'(bus.alu_ready), 64'd1);
      chk("midrst.lsu_ready", 64'(bus.lsu_ready), 64'd1);
      chk("midrst.wb_data",   64'(bus.wb_data),   64'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("midrst.c%0d.wb_en", k), 64'(bus.wb_en), 64'd0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
